// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding, parity helper.
// Used by the configurable transmitter and the future configurable receiver.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam logic [1:0] PARITY_MARK = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // data_xor is the XOR-reduction of the character; PARITY_NONE never reaches the line.
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        case (mode)
            PARITY_ODD:  parity_bit = ~data_xor;
            PARITY_EVEN: parity_bit = data_xor;
            default:     parity_bit = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample divider: counts tick_os pulses and flags the last tick of each bit period.
// Latency: bit_end is combinational from tick_os and the sub counter.
// Backpressure: none; clear holds the counter at zero.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_os,
    input  logic clear,
    output logic bit_end
);

    localparam int SUB_W = $clog2(OVERSAMPLE);

    logic [SUB_W-1:0] sub;

    assign bit_end = tick_os && (sub == SUB_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sub <= '0;
        end else if (tick_os) begin
            sub <= bit_end ? '0 : sub + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data, optional parity, 1/2 stop bits, LSB first.
// Latency: accepted character starts its start bit one clk after the accept edge when idle.
// Backpressure: s_ready low while the one-entry holding register is full.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_os,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par_en, par_bit, stop2_q;
    logic                 tx_n, busy_n, done_n;
    logic                 load;
    logic                 bit_end;

    assign s_ready = ~hold_full;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .tick_os (tick_os),
        .clear   ((state == TX_IDLE) || load),
        .bit_end (bit_end)
    );

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bitcnt_n   = bitcnt;
        stop_cnt_n = stop_cnt;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = 1'b0;
        load       = 1'b0;
        case (state)
            TX_IDLE: begin
                load = hold_full;
            end
            TX_START: begin
                if (bit_end) begin
                    state_n = TX_DATA;
                    tx_n    = shreg[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shreg_n  = shreg >> 1;
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == BW'(DATA_BITS - 1)) begin
                        if (par_en) begin
                            state_n = TX_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n    = TX_STOP;
                            tx_n       = 1'b1;
                            stop_cnt_n = 1'b0;
                        end
                    end else begin
                        tx_n = shreg[1];
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_n    = TX_STOP;
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == stop2_q) begin
                        done_n = 1'b1;
                        // A waiting character starts immediately: no idle bit between frames.
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_n = TX_IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: state_n = TX_IDLE;
        endcase
        if (load) begin
            state_n  = TX_START;
            shreg_n  = hold;
            bitcnt_n = '0;
            tx_n     = 1'b0;
            busy_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TX_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            bitcnt    <= '0;
            stop_cnt  <= 1'b0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop2_q   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            stop_cnt <= stop_cnt_n;
            tx       <= tx_n;
            busy     <= busy_n;
            tx_done  <= done_n;
            if (s_valid && s_ready) begin
                hold      <= s_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            // Line configuration is frozen per frame at load time.
            if (load) begin
                par_en  <= (parity_mode != PARITY_NONE);
                par_bit <= parity_bit(parity_mode, ^hold);
                stop2_q <= stop2;
            end
        end
    end

endmodule
